// File: rtl/pit_bus_master.sv
// pit_bus_master: host-side initiator for an 8254 interval timer.
// Turns one command at a time into byte-wide 8254 bus cycles and keeps a
// shadow copy of each counter's RW format so count accesses use the right
// LSB/MSB sequence.
// Optional feature macro: PIT_READBACK_EN (op 11 read-back status sequence).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | CS_n low, address (and write data) presented for one cycle
// STROBE | RD_n or WR_n low for STROBE_CYC cycles, read data sampled last
// HOLD   | strobe released, CS_n/A/D_out held one cycle
// RESP   | one-cycle rsp_valid pulse
module pit_bus_master #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_counter,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic [1:0]  A,
  output logic        CS_n,
  output logic        RD_n,
  output logic        WR_n,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in
);

  localparam logic [1:0] OP_CTRL = 2'b00;
  localparam logic [1:0] OP_CWR  = 2'b01;
  localparam logic [1:0] OP_CRD  = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;

  localparam logic [3:0] STB_LOAD = 4'(STROBE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  op_q;
  logic [1:0]  ctr_q;
  logic [15:0] data_q;
  logic [1:0]  rw_q;
  logic        err_q;
  logic        byte_idx;
  logic [3:0]  stb_cnt;
  logic [7:0]  rd_lo;
  logic [7:0]  rd_hi;
  logic [1:0]  rw_shadow [0:2];

  logic [1:0]  cmd_rw;
  logic        op_unsupported;
  logic        cmd_illegal;

  logic        byte_wr;
  logic [1:0]  byte_addr;
  logic [7:0]  byte_wdata;
  logic        byte_hi;
  logic        byte_last;

`ifdef PIT_READBACK_EN
  // Read-back command latching status only for the selected counter.
  logic [7:0]  rb_cmd;
  assign rb_cmd = 8'hE0 | (8'h01 << ({1'b0, ctr_q} + 3'd1));
  assign op_unsupported = 1'b0;
`else
  assign op_unsupported = (cmd_op == OP_STAT);
`endif

  // Look up the RW format of the counter addressed by the incoming command.
  always_comb begin
    cmd_rw = 2'b00;
    case (cmd_counter)
      2'd0:    cmd_rw = rw_shadow[0];
      2'd1:    cmd_rw = rw_shadow[1];
      2'd2:    cmd_rw = rw_shadow[2];
      default: cmd_rw = 2'b00;
    endcase
  end

  assign cmd_illegal = ((cmd_op != OP_CTRL) && (cmd_counter == 2'd3)) ||
                       (((cmd_op == OP_CWR) || (cmd_op == OP_CRD)) && (cmd_rw == 2'b00)) ||
                       op_unsupported;

  // Describe the bus byte currently in flight from the latched command.
  always_comb begin
    byte_wr    = 1'b1;
    byte_addr  = ctr_q;
    byte_wdata = 8'h00;
    byte_hi    = 1'b0;
    byte_last  = 1'b1;
    case (op_q)
      OP_CTRL: begin
        byte_addr  = 2'b11;
        byte_wdata = data_q[7:0];
      end
      OP_CWR: begin
        byte_hi    = (rw_q == 2'b10) || byte_idx;
        byte_wdata = byte_hi ? data_q[15:8] : data_q[7:0];
        byte_last  = (rw_q != 2'b11) || byte_idx;
      end
      OP_CRD: begin
        byte_wr    = 1'b0;
        byte_hi    = (rw_q == 2'b10) || byte_idx;
        byte_last  = (rw_q != 2'b11) || byte_idx;
      end
`ifdef PIT_READBACK_EN
      OP_STAT: begin
        if (!byte_idx) begin
          byte_addr  = 2'b11;
          byte_wdata = rb_cmd;
          byte_last  = 1'b0;
        end else begin
          byte_wr    = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and bus/handshake outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    CS_n      = 1'b1;
    RD_n      = 1'b1;
    WR_n      = 1'b1;
    A         = 2'b00;
    D_out     = 8'h00;
    D_oe      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_illegal ? S_RESP : S_SETUP;
      end
      S_SETUP: begin
        CS_n      = 1'b0;
        A         = byte_addr;
        D_oe      = byte_wr;
        D_out     = byte_wr ? byte_wdata : 8'h00;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        CS_n  = 1'b0;
        A     = byte_addr;
        D_oe  = byte_wr;
        D_out = byte_wr ? byte_wdata : 8'h00;
        RD_n  = byte_wr;
        WR_n  = !byte_wr;
        if (stb_cnt == 4'd0) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        CS_n      = 1'b0;
        A         = byte_addr;
        D_oe      = byte_wr;
        D_out     = byte_wr ? byte_wdata : 8'h00;
        state_nxt = byte_last ? S_RESP : S_SETUP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, strobe timer, read capture, response data and RW shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 2'b00;
      ctr_q    <= 2'b00;
      data_q   <= 16'h0000;
      rw_q     <= 2'b00;
      err_q    <= 1'b0;
      byte_idx <= 1'b0;
      stb_cnt  <= 4'd0;
      rd_lo    <= 8'h00;
      rd_hi    <= 8'h00;
      rsp_data <= 16'h0000;
      for (int i = 0; i < 3; i++) rw_shadow[i] <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            ctr_q    <= cmd_counter;
            data_q   <= cmd_data;
            rw_q     <= cmd_rw;
            err_q    <= cmd_illegal;
            byte_idx <= 1'b0;
            rd_lo    <= 8'h00;
            rd_hi    <= 8'h00;
            if (cmd_illegal) rsp_data <= 16'h0000;
          end
        end
        S_SETUP: stb_cnt <= STB_LOAD;
        S_STROBE: begin
          if (stb_cnt != 4'd0) begin
            stb_cnt <= stb_cnt - 4'd1;
          end else if (!byte_wr) begin
            if (byte_hi) rd_hi <= D_in;
            else         rd_lo <= D_in;
          end
        end
        S_HOLD: begin
          if (byte_last) begin
            rsp_data <= ((op_q == OP_CRD) || (op_q == OP_STAT)) ? {rd_hi, rd_lo} : 16'h0000;
          end else begin
            byte_idx <= 1'b1;
          end
        end
        S_RESP: begin
          // Latch (RW=00) and read-back (SC=11) control bytes leave formats alone.
          if ((op_q == OP_CTRL) && !err_q && (data_q[5:4] != 2'b00)) begin
            case (data_q[7:6])
              2'd0:    rw_shadow[0] <= data_q[5:4];
              2'd1:    rw_shadow[1] <= data_q[5:4];
              2'd2:    rw_shadow[2] <= data_q[5:4];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pit_bus_master.sv
// Directed bench for pit_bus_master: expected bus bytes and responses are
// queued when a command is issued and popped as the DUT produces them.
module tb_pit_bus_master;

  localparam int STB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_counter = 2'b00;
  logic [15:0] cmd_data = 16'h0000;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [1:0]  A;
  logic        CS_n;
  logic        RD_n;
  logic        WR_n;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in = 8'h00;

  int checks = 0;
  int failures = 0;

  typedef struct {bit wr; logic [1:0] a; logic [7:0] d;} bus_t;
  typedef struct {bit err; logic [15:0] data; int lat;} rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  pit_bus_master #(.STROBE_CYC(STB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_counter(cmd_counter), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .A(A), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_byte(input bit wr, input logic [1:0] a, input logic [7:0] d);
    exp_bus.push_back('{wr, a, d});
  endtask

  // Issue one command and follow it cycle by cycle until its response.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] ctr, input logic [15:0] data,
                         input bit err, input logic [15:0] rdata);
    int   n;
    int   lat;
    bit   got;
    bit   done;
    bit   low;
    bit   prev_low;
    int   low_len;
    bus_t e;
    rsp_t r;
    n   = exp_bus.size();
    lat = err ? 1 : n * (STB + 2) + 1;
    exp_rsp.push_back('{err, rdata, lat});
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_counter = ctr;
    cmd_data    = data;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", got, 1);
    if (!got) begin
      cmd_valid = 1'b0;
      exp_bus.delete();
      exp_rsp.delete();
      return;
    end
    done = 1'b0;
    prev_low = 1'b0;
    low_len = 0;
    for (int t = 1; t <= 300 && !done; t++) begin
      @(negedge clk);
      if (t == 1) cmd_valid = 1'b0;
      chk("rd_wr_exclusive", (!RD_n && !WR_n), 0);
      if (!RD_n) chk("oe_during_read", D_oe, 0);
      if (n == 0) chk("cs_quiet", CS_n, 1);
      low = !RD_n || !WR_n;
      if (low && !prev_low) begin
        chk("byte_expected", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) begin
          e = exp_bus.pop_front();
          chk("dir", !WR_n, e.wr);
          chk("addr", A, e.a);
          chk("cs_low", CS_n, 0);
          if (e.wr) begin
            chk("wdata", D_out, e.d);
            chk("oe_write", D_oe, 1);
          end else begin
            D_in = e.d;
          end
        end
        low_len = 0;
      end
      if (low) low_len++;
      if (!low && prev_low) chk("strobe_len", low_len, STB);
      prev_low = low;
      if (rsp_valid) begin
        chk("rsp_expected", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_data", rsp_data, r.data);
          chk("latency", t, r.lat);
        end
        done = 1'b1;
      end
    end
    chk("rsp_seen", done, 1);
    chk("bytes_left", exp_bus.size(), 0);
    @(negedge clk);
    chk("ready_after", cmd_ready, 1);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_data_hold", rsp_data, rdata);
    exp_bus.delete();
    exp_rsp.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_bus", {CS_n, RD_n, WR_n, D_oe}, 4'b1110);
    chk("rst_a_dout", {A, D_out}, 10'h000);
    rst = 1'b0;

    // Unprogrammed counter rejected without bus activity.
    run_cmd(2'b01, 2'd0, 16'h1234, 1'b1, 16'h0000);

    // Counter 0 RW=11, then LSB/MSB count write.
    exp_byte(1'b1, 2'b11, 8'h34);
    run_cmd(2'b00, 2'd0, 16'h0034, 1'b0, 16'h0000);
    exp_byte(1'b1, 2'b00, 8'h34);
    exp_byte(1'b1, 2'b00, 8'h12);
    run_cmd(2'b01, 2'd0, 16'h1234, 1'b0, 16'h0000);

    // Counter 1 RW=01, single LSB read.
    exp_byte(1'b1, 2'b11, 8'h50);
    run_cmd(2'b00, 2'd1, 16'h0050, 1'b0, 16'h0000);
    exp_byte(1'b0, 2'b01, 8'hA5);
    run_cmd(2'b10, 2'd1, 16'h0000, 1'b0, 16'h00A5);

    // Counter 2 RW=11, LSB then MSB read.
    exp_byte(1'b1, 2'b11, 8'hB4);
    run_cmd(2'b00, 2'd2, 16'h00B4, 1'b0, 16'h0000);
    exp_byte(1'b0, 2'b10, 8'h78);
    exp_byte(1'b0, 2'b10, 8'h56);
    run_cmd(2'b10, 2'd2, 16'h0000, 1'b0, 16'h5678);

    // Counter 1 reprogrammed to RW=10: MSB-only write.
    exp_byte(1'b1, 2'b11, 8'h60);
    run_cmd(2'b00, 2'd1, 16'h0060, 1'b0, 16'h0000);
    exp_byte(1'b1, 2'b01, 8'hAB);
    run_cmd(2'b01, 2'd1, 16'hABCD, 1'b0, 16'h0000);

    // Latch command keeps RW=10: MSB-only read lands in the upper byte.
    exp_byte(1'b1, 2'b11, 8'h40);
    run_cmd(2'b00, 2'd1, 16'h0040, 1'b0, 16'h0000);
    exp_byte(1'b0, 2'b01, 8'h9C);
    run_cmd(2'b10, 2'd1, 16'h0000, 1'b0, 16'h9C00);

    // Raw read-back byte via op 00 leaves counter 2 at RW=11.
    exp_byte(1'b1, 2'b11, 8'hE4);
    run_cmd(2'b00, 2'd3, 16'h00E4, 1'b0, 16'h0000);
    exp_byte(1'b0, 2'b10, 8'h11);
    exp_byte(1'b0, 2'b10, 8'h22);
    run_cmd(2'b10, 2'd2, 16'h0000, 1'b0, 16'h2211);

    // Counter select 3 is illegal for count ops.
    run_cmd(2'b10, 2'd3, 16'h0000, 1'b1, 16'h0000);

    // Status read.
`ifdef PIT_READBACK_EN
    exp_byte(1'b1, 2'b11, 8'hE4);
    exp_byte(1'b0, 2'b01, 8'h36);
    run_cmd(2'b11, 2'd1, 16'h0000, 1'b0, 16'h0036);
`else
    run_cmd(2'b11, 2'd1, 16'h0000, 1'b1, 16'h0000);
`endif

    // Reset during the second strobe cycle of a count write (counter 0 RW=11).
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = 2'b01;
    cmd_counter = 2'd0;
    cmd_data    = 16'h1111;
    chk("rst_case_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_case_setup_cs", CS_n, 0);
    @(negedge clk);
    chk("rst_case_strobe1", WR_n, 0);
    @(negedge clk);
    chk("rst_case_strobe2", WR_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_case_strobes", {CS_n, RD_n, WR_n}, 3'b111);
    chk("rst_case_oe", D_oe, 0);
    chk("rst_case_ready_after", cmd_ready, 1);
    chk("rst_case_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || !CS_n) seen++;
    end
    chk("rst_case_quiet", seen, 0);

    // Shadow was cleared by reset.
    run_cmd(2'b01, 2'd0, 16'h1234, 1'b1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pit_bus_master.md
# pit_bus_master

Host-side bus initiator for the 8254 programmable interval timer. Accepts one command at a time on a valid/ready interface and converts it into 8254 byte-wide bus cycles on A/CS/RD/WR/D:
- control-word writes
- count loads
- count reads
- optional read-back status reads

It keeps a shadow copy of each counter's read/write (RW) format, so count accesses automatically use the correct LSB/MSB byte sequence. It sits between the system-side register/command fabric and the timer's control-logic port.

## Interface
Parameters:
- STROBE_CYC, default 2: clock cycles RD or WR is held low per byte (legal 1..15).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, input, 1: clock.
  - rst, input, 1: synchronous, active-high reset.
- Command interface:
  - cmd_valid, input, 1: command request.
  - cmd_ready, output, 1: high only in IDLE.
  - cmd_op, input, 2: 00 control write, 01 count write, 10 count read, 11 status read.
  - cmd_counter, input, 2: counter select 0..2 (3 is illegal for ops 01/10/11).
  - cmd_data, input, 16: control byte in [7:0] for op 00; count value for op 01.
- Response interface:
  - rsp_valid, output, 1: one-cycle completion pulse.
  - rsp_err, output, 1: qualifies rsp_valid; command rejected, no bus cycle issued.
  - rsp_data, output, 16: read result; 0 for writes and errors.
- 8254 bus:
  - A, output, 2: 8254 address.
  - CS_n, output, 1: chip select, active low.
  - RD_n, output, 1: read strobe, active low.
  - WR_n, output, 1: write strobe, active low.
  - D_out, output, 8: write data.
  - D_oe, output, 1: data bus drive enable.
  - D_in, input, 8: read data from the 8254.

## Operation
Shadow RW state:
- rw_shadow[0..2], 2 bits each; 00 = unprogrammed.
- A control write with byte[7:6]≠11 and byte[5:4]≠00 sets rw_shadow[byte[7:6]] = byte[5:4].
- Latch commands (byte[5:4]=00) and read-back commands (byte[7:6]=11) leave the shadow unchanged.

Byte sequencing per op:
- op 00: one write byte to A=11; D_out=cmd_data[7:0].
- op 01: writes to A=cmd_counter.
  - RW 01: cmd_data[7:0].
  - RW 10: cmd_data[15:8].
  - RW 11: LSB then MSB, as two complete bus cycles.
- op 10: reads from A=cmd_counter, using the same byte order as op 01.
  - rsp_data = {00,lsb}, {msb,00} or {msb,lsb} respectively.
- op 11 (PIT_READBACK_EN only): two bus cycles.
  - First, write to A=11 with byte 8'b1110_0000 | (1<<(cmd_counter+1)), i.e. latch status only.
  - Then read one byte from A=cmd_counter; rsp_data={8'h00,status}.

Errors: rsp_err=1 and no bus activity for any of:
- cmd_counter=3 with op≠00;
- op 01/10 on an unprogrammed counter;
- op 11 when the feature is compiled out.

FSM states:
- IDLE: cmd_ready=1; cmd_valid&cmd_ready latches the command.
  - Legal command → SETUP.
  - Illegal command → RESP.
- SETUP: 1 cycle.
  - CS_n=0 and A valid.
  - For a write, D_oe=1 and D_out valid.
  - → STROBE.
- STROBE: STROBE_CYC cycles with RD_n or WR_n =0.
  - Read data: D_in is sampled on the last STROBE cycle.
  - → HOLD.
- HOLD: 1 cycle.
  - Strobe high; CS_n, A and D_out held.
  - If more bytes remain → SETUP, otherwise → RESP.
- RESP: 1 cycle; rsp_valid=1 → IDLE.

Bus rules:
- RD_n and WR_n are never low simultaneously.
- D_oe=0 whenever RD_n=0 and in IDLE.

## Timing
- Reset values:
  - FSM=IDLE, cmd_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - CS_n=1, RD_n=1, WR_n=1.
  - A=0, D_out=0, D_oe=0.
  - rw_shadow all 00.
- Byte cost: STROBE_CYC+2 cycles per byte.
- Latency from accept to rsp_valid: N·(STROBE_CYC+2)+1 cycles, where N = number of bytes. N=0 for an error, giving latency 1.
- rsp_data is valid only while rsp_valid=1, and holds until the next response.
- A new command is accepted at the earliest in the cycle after RESP.
- cmd_valid while busy is ignored; the host holds it until ready.
- rst asserted mid-operation: the next clock edge forces the reset values, strobes are deasserted immediately, and no response is issued.
- A control write that reprograms a counter updates rw_shadow in its RESP cycle, so the following command sees the new format.

## Configuration
- PIT_READBACK_EN defined: op 11 performs the read-back status sequence above.
- PIT_READBACK_EN undefined: the status path is not synthesized, and op 11 returns rsp_err=1 with latency 1 and no bus cycle.
- In both cases, op 00 can still send any raw read-back byte.

## Test plan
- After reset, op 01 to counter 0 → rsp_err=1 within 1 cycle; CS_n stays 1.
- op 00 data 8'h34, then op 01 counter 0 data 16'h1234, STROBE_CYC=2 → two WR_n pulses of 2 cycles each; bytes 8'h34 then 8'h12 at A=00; rsp_valid 9 cycles after accept.
- op 00 data 8'h50 (counter 1, RW=01), then op 10 counter 1 with D_in=8'hA5 → single RD_n pulse at A=01; rsp_data=16'h00A5.
- op 00 data 8'hB4, then op 10 counter 2 with D_in=8'h78 then 8'h56 → rsp_data=16'h5678.
- With PIT_READBACK_EN, op 11 counter 1 → write 8'hE4 to A=11, then read A=01, D_in=8'h36 → rsp_data=16'h0036. Without the macro → rsp_err=1.
- Assert rst during the second STROBE cycle of a count write → RD_n/WR_n/CS_n high on the next edge, no rsp_valid, cmd_ready=1.
